// File: rtl/hamming_branch_metric_seq_if.sv
// hamming_branch_metric_seq_if: job/metric bus; master drives st, data_in, erase, bm_ready; slave drives state_idx, bm0, bm1, bm_valid, busy, done
interface hamming_branch_metric_seq_if #(
  parameter int N = 2,
  parameter int K = 3
) ();
  localparam int MW = $clog2(N + 1);
  logic st;
  logic [N-1:0] data_in;
  logic [N-1:0] erase;
  logic bm_ready;
  logic [K-2:0] state_idx;
  logic [MW-1:0] bm0;
  logic [MW-1:0] bm1;
  logic bm_valid;
  logic busy;
  logic done;
  modport master (
    output st, data_in, erase, bm_ready,
    input state_idx, bm0, bm1, bm_valid, busy, done
  );
  modport slave (
    input st, data_in, erase, bm_ready,
    output state_idx, bm0, bm1, bm_valid, busy, done
  );
endinterface

// File: rtl/hamming_branch_metric_seq.sv
// hamming_branch_metric_seq: streams per-state Hamming branch metrics (bm0/bm1) for one captured symbol; ports clk, rst (async high), bus (slave: st/data_in/erase/bm_ready in, state_idx/bm0/bm1/bm_valid/busy/done out)
module hamming_branch_metric_seq #(
  parameter int N = 2,
  parameter int K = 3,
  parameter logic [N*K-1:0] G = 6'b101_111
) (
  input logic clk,
  input logic rst,
  hamming_branch_metric_seq_if.slave bus
);
  localparam int MW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic start, accept;
  logic [K-2:0] idx, idx_nx;
  logic [N-1:0] data_cap, erase_cap, data_nx, erase_nx;
  logic [MW-1:0] bm0, bm1;
  function automatic logic [MW-1:0] metric(input logic [K-1:0] r, input logic [N-1:0] d, input logic [N-1:0] e);
    logic [MW-1:0] c;
    c = '0;
    for (int j = 0; j < N; j++) c += MW'((^(r & G[j*K +: K]) ^ d[j]) & ~e[j]);
    return c;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    start = state == IDLE && bus.st;
    accept = state == RUN && bus.bm_ready;
    state_nx = start ? RUN : (accept && (&idx)) ? DONE : state == DONE ? IDLE : state;
  end
  always_comb begin
    bus.state_idx = idx;
    bus.bm0 = bm0;
    bus.bm1 = bm1;
    bus.bm_valid = state == RUN;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // metrics are computed from the next index/capture so they are registered alongside state_idx
  always_comb begin
    idx_nx = start ? '0 : accept ? idx + {{(K-2){1'b0}}, 1'b1} : idx;
    data_nx = start ? bus.data_in : data_cap;
    erase_nx = start ? bus.erase : erase_cap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      data_cap <= '0;
      erase_cap <= '0;
      bm0 <= '0;
      bm1 <= '0;
    end else begin
      idx <= idx_nx;
      data_cap <= data_nx;
      erase_cap <= erase_nx;
      bm0 <= metric({1'b0, idx_nx}, data_nx, erase_nx);
      bm1 <= metric({1'b1, idx_nx}, data_nx, erase_nx);
    end
  end
endmodule

// File: doc/hamming_branch_metric_seq.md
HAMMING_BRANCH_METRIC_SEQ -- requirements
Module: hamming_branch_metric_seq

Interface
REQ-001 Parameter N, default 2: code outputs per input bit (legal 2..4).
REQ-002 Parameter K, default 3: constraint length (legal 3..7); number of trellis states S = 2^(K-1).
REQ-003 Parameter G, default 6'b101_111: N*K bits packed {G[N-1],...,G[0]}; G[j] is the K-bit generator for code bit j (default G[0]=111, G[1]=101).
REQ-004 Derived width MW = $clog2(N+1) for every metric output.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 st  input  1  start request; sampled only in IDLE.
REQ-008 data_in  input  N  received hard-decision symbol; bit j is code bit j.
REQ-009 erase  input  N  puncture/erasure mask; bit j high excludes code bit j from metrics.
REQ-010 bm_ready  input  1  downstream accepts current metric beat.
REQ-011 state_idx  output  K-1  trellis state the current beat refers to.
REQ-012 bm0  output  MW  Hamming distance for branch with input bit 0 into state_idx.
REQ-013 bm1  output  MW  Hamming distance for branch with input bit 1.
REQ-014 bm_valid  output  1  metric beat valid.
REQ-015 busy  output  1  high in RUN and DONE.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-017 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: on edge with st=1, capture data_in and erase, set state counter to 0, go to RUN; st=0 stays in IDLE.
REQ-019 Beat for state s: r_b = {b, s} (K bits, b in MSB); expected bit j = XOR-reduce(r_b & G[j]); bm_b = popcount((expected ^ data_cap) & ~erase_cap).
REQ-020 First beat (state_idx=0, bm_valid=1) appears in the cycle immediately after the st capture edge (latency 1).
REQ-021 Beat accepted on edge with bm_valid=1 and bm_ready=1; counter then increments and next beat presents the following cycle.
REQ-022 bm_valid=1 and bm_ready=0: state_idx, bm0, bm1 held stable; no counter advance.
REQ-023 Acceptance of beat state_idx=S-1 moves FSM to DONE; bm_valid=0 next cycle.
REQ-024 DONE lasts exactly one cycle with done=1, then IDLE; done=0 in all other cycles.
REQ-025 st ignored in RUN and DONE; data_in/erase changes after capture do not affect metrics.
REQ-026 st=1 in DONE cycle is ignored; a new job requires st=1 while in IDLE.
REQ-027 erase all ones: every bm0=bm1=0; all beats still produced.
REQ-028 Metrics never exceed N; no saturation logic required.

Reset
REQ-029 rst=1 forces IDLE asynchronously: bm_valid=0, done=0, busy=0, state_idx=0, bm0=0, bm1=0, captured registers cleared.
REQ-030 rst asserted mid-RUN aborts the job; no done pulse; after release, block waits for st in IDLE.

Verification (defaults N=2, K=3)
REQ-031 data_in=00, erase=00, st pulse, bm_ready=1 -> beats (s,bm0,bm1) = (0,0,2),(1,2,0),(2,1,1),(3,1,1) on 4 consecutive cycles, then done one cycle, busy low after.
REQ-032 data_in=11, erase=00 -> (0,2,0),(1,0,2),(2,1,1),(3,1,1).
REQ-033 data_in=00, erase=10 -> (0,0,1),(1,1,0),(2,1,0),(3,0,1); erase=11 -> all metrics 0.
REQ-034 bm_ready low 3 cycles during state 1 beat -> state_idx=1, bm0=2, bm1=0 held 4 cycles; total job 7 beat cycles; st pulses during RUN ignored.
REQ-035 rst pulse during state 2 beat -> outputs zero immediately (before next edge), no done; new st with data_in=11 then yields REQ-032 sequence.
REQ-036 Parameter sweep N=3, K=4, G={1101,1111,1011}: 8 beats, MW=2, metrics match reference model computed per REQ-019.
